// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, rippled borrow.
// start/busy/done framed; WIDTH+2 cycles per operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             bo_q, bo_d;
  logic             d_bit;
  logic             bw_nx;

  // Full-subtractor cell on the current LSBs
  assign d_bit = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_nx = (~a_q[0] & b_q[0])
               | (~(a_q[0] ^ b_q[0]) & bw_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bw_d   = bw_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          bo_d    = bw_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      bo_q    <= bo_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Expectations queued at issue, checked on every done pulse.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, bo8;
  logic [7:0]  diff8;

  logic        s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bo16;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8),
    .a(a8), .b(b8), .busy(busy8),
    .done(done8), .diff(diff8),
    .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16),
    .a(a16), .b(b16), .busy(busy16),
    .done(done16), .diff(diff16),
    .borrow_out(bo16)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int checks = 0;
  int failures = 0;
  logic d8_prev = 1'b0;
  logic d16_prev = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      chk("done8_pulse_width", 32'(d8_prev), 0);
      if (q8.size() == 0) begin
        chk("done8_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e.d[7:0]));
        chk("borrow8", 32'(bo8), 32'(e.bo));
      end
    end
    d8_prev <= done8;
  end

  always @(negedge clk) begin
    if (done16) begin
      chk("done16_pulse_width", 32'(d16_prev), 0);
      if (q16.size() == 0) begin
        chk("done16_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("diff16", 32'(diff16), 32'(e.d));
        chk("borrow16", 32'(bo16), 32'(e.bo));
      end
    end
    d16_prev <= done16;
  end

  task automatic wait_done8(output int nb);
    nb = 0;
    for (int i = 0; i < 40 && !done8; i++) begin
      if (busy8) nb++;
      @(negedge clk);
    end
    if (!done8) chk("timeout8", 0, 1);
  endtask

  task automatic op8(input logic [7:0] x,
                     input logic [7:0] y,
                     input logic [7:0] ed,
                     input logic       eb,
                     output int        nb);
    exp_t e;
    @(negedge clk);
    a8 = x; b8 = y; s8 = 1'b1;
    e.d = {8'h00, ed}; e.bo = eb;
    q8.push_back(e);
    @(negedge clk);
    s8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    wait_done8(nb);
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] x,
                      input logic [15:0] y,
                      input logic [15:0] ed,
                      input logic        eb);
    exp_t e;
    @(negedge clk);
    a16 = x; b16 = y; s16 = 1'b1;
    e.d = ed; e.bo = eb;
    q16.push_back(e);
    @(negedge clk);
    s16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    for (int i = 0; i < 60 && !done16; i++)
      @(negedge clk);
    if (!done16) chk("timeout16", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int nb;
    int c;
    int cnt;
    logic prev;
    logic [7:0] x, y;
    logic [15:0] x16, y16;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_outs8",
        {diff8, busy8, done8, bo8}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs8",
        {diff8, busy8, done8, bo8}, 0);
    chk("idle_outs16",
        {diff16, busy16, done16, bo16}, 0);

    op8(8'd200, 8'd55, 8'd145, 1'b0, nb);
    chk("busy_cycles", nb, 8);
    chk("done_fall", 32'(done8), 0);

    op8(8'd5, 8'd10, 8'hFB, 1'b1, nb);
    op8(8'h00, 8'h01, 8'hFF, 1'b1, nb);
    op8(8'hAA, 8'hAA, 8'h00, 1'b0, nb);
    chk("hold_diff", 32'(diff8), 0);
    chk("hold_bo", 32'(bo8), 0);

    // start held high across two operations
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; s8 = 1'b1;
    e.d = 16'h000F; e.bo = 1'b0; q8.push_back(e);
    e.d = 16'h00F1; e.bo = 1'b1; q8.push_back(e);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h10;
    c = 0;
    prev = busy8;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      c++;
      if (busy8 && !prev) break;
      prev = busy8;
    end
    chk("accept_spacing", c, 10);
    s8 = 1'b0;
    wait_done8(nb);
    @(negedge clk);

    // spurious starts in RUN and DONE
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h7F; s8 = 1'b1;
    e.d = 16'h0001; e.bo = 1'b0; q8.push_back(e);
    @(negedge clk);
    s8 = 1'b0; a8 = 8'h33; b8 = 8'h11;
    repeat (2) @(negedge clk);
    s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait_done8(nb);
    a8 = 8'h44; b8 = 8'h22; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy8 || done8) cnt++;
      @(negedge clk);
    end
    chk("no_extra_op", cnt, 0);

    // asynchronous abort mid-operation
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", 32'(busy8), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs",
        {diff8, busy8, done8, bo8}, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    op8(8'h03, 8'h02, 8'h01, 1'b0, nb);

    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      op8(x, y, x - y, x < y, nb);
    end

    op16(16'h1234, 16'h0235, 16'h0FFF, 1'b0);
    op16(16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    op16(16'h8000, 16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      op16(x16, y16, x16 - y16, x16 < y16);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
